// File: rtl/cmos_pkg.sv
// cmos_pkg: constants shared by the CMOS camera stream generator.
//   - FSM state encodings (3-bit, IDLE..VFRONT)
//   - pattern selector encoding
//   - the eight RGB565 colour-bar values and a lookup helper
package cmos_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFRONT = 3'd4;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  localparam logic [15:0] COL_WHITE   = 16'hFFFF;
  localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COL_CYAN    = 16'h07FF;
  localparam logic [15:0] COL_GREEN   = 16'h07E0;
  localparam logic [15:0] COL_MAGENTA = 16'hF81F;
  localparam logic [15:0] COL_RED     = 16'hF800;
  localparam logic [15:0] COL_BLUE    = 16'h001F;
  localparam logic [15:0] COL_BLACK   = 16'h0000;

  // Bar index 0 is the leftmost bar.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmos_pattern_rom.sv
// cmos_pattern_rom: combinational test-pattern generator.
// Ports:
//   pattern_sel_i  2-bit pattern select (bars, ramp, solid, checkerboard)
//   x_i            pixel column within the line
//   y_i            active line number within the frame
//   solid_color_i  RGB565 colour used by the solid pattern
//   pix_o          RGB565 pixel value
module cmos_pattern_rom
  import cmos_pkg::*;
#(
  parameter logic [9:0] H_PIXELS = 10'd640
) (
  input  logic [1:0]  pattern_sel_i,
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [15:0] solid_color_i,
  output logic [15:0] pix_o
);

  logic [18:0] bar_scaled;
  logic [18:0] bar_full;
  logic [2:0]  bar_idx;

  always_comb begin
    // bar = x*8/H_PIXELS; divisor is a constant so this folds to fixed logic.
    bar_scaled = {x_i, 3'b000};
    bar_full   = bar_scaled / {9'd0, H_PIXELS};
    bar_idx    = (bar_full > 19'd7) ? 3'd7 : bar_full[2:0];
  end

  always_comb begin
    pix_o = 16'h0000;
    case (pattern_e'(pattern_sel_i))
      PAT_BARS:  pix_o = bar_color(bar_idx);
      PAT_RAMP:  pix_o = x_i + y_i;
      PAT_SOLID: pix_o = solid_color_i;
      PAT_CHECK: pix_o = (x_i[3] ^ y_i[3]) ? 16'hFFFF : 16'h0000;
      default:   pix_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/cmos_stream_gen.sv
// cmos_stream_gen: emulates a CMOS image sensor's parallel output
// (vsync / href / 8-bit data, RGB565 high byte first) carrying test patterns.
// Ports:
//   cam_pclk     pixel clock, all state changes on its rising edge
//   rst_n        synchronous active-low reset
//   gen_en       run request, sampled only at frame boundaries
//   pattern_sel  pattern select, latched at frame start
//   solid_color  RGB565 colour for the solid pattern, latched at frame start
//   cam_vsync    frame sync, active high
//   cam_href     line valid, high only during active bytes
//   cam_data     pixel byte stream, 00 whenever href is low
//   frame_done   one-cycle pulse on the last cycle of the front porch
//
// state  | meaning
// IDLE   | stopped, waiting for gen_en
// VSYNC  | VS_LINES line periods with cam_vsync high
// VBACK  | V_BACK blank line periods
// ACTIVE | V_LINES lines: 2*H_PIXELS href-high cycles then H_BLANK low
// VFRONT | V_FRONT blank line periods; last cycle pulses frame_done
module cmos_stream_gen
  import cmos_pkg::*;
#(
  parameter logic [9:0] H_PIXELS = 10'd640,
  parameter logic [9:0] V_LINES  = 10'd480,
  parameter logic [9:0] H_BLANK  = 10'd144,
  parameter logic [9:0] VS_LINES = 10'd3,
  parameter logic [9:0] V_BACK   = 10'd17,
  parameter logic [9:0] V_FRONT  = 10'd10
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        gen_en,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done
);

  localparam logic [15:0] ACT_CYC  = 16'(32'(H_PIXELS) * 2);
  localparam logic [15:0] LINE_CYC = ACT_CYC + 16'(H_BLANK);
  localparam logic [15:0] H_LAST   = LINE_CYC - 16'd1;
  localparam logic [15:0] VS_LAST  = 16'(VS_LINES) - 16'd1;
  localparam logic [15:0] VB_LAST  = 16'(V_BACK) - 16'd1;
  localparam logic [15:0] VA_LAST  = 16'(V_LINES) - 16'd1;
  localparam logic [15:0] VF_LAST  = 16'(V_FRONT) - 16'd1;

  logic [2:0]  state_q, state_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] solid_q, solid_d;

  logic        line_end;
  logic        seg_end;
  logic [15:0] seg_last;
  logic [15:0] pix;

  // Line count at which the current state's segment ends.
  always_comb begin
    seg_last = 16'd0;
    case (state_q)
      ST_VSYNC:  seg_last = VS_LAST;
      ST_VBACK:  seg_last = VB_LAST;
      ST_ACTIVE: seg_last = VA_LAST;
      ST_VFRONT: seg_last = VF_LAST;
      default:   seg_last = 16'd0;
    endcase
  end

  assign line_end = (h_cnt_q == H_LAST);
  assign seg_end  = (line_cnt_q == seg_last);

  always_comb begin
    state_d    = state_q;
    h_cnt_d    = h_cnt_q;
    line_cnt_d = line_cnt_q;
    pat_d      = pat_q;
    solid_d    = solid_q;
    case (state_q)
      ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT: begin
        if (line_end) begin
          h_cnt_d = 16'd0;
          if (seg_end) begin
            line_cnt_d = 16'd0;
            case (state_q)
              ST_VSYNC:  state_d = ST_VBACK;
              ST_VBACK:  state_d = ST_ACTIVE;
              ST_ACTIVE: state_d = ST_VFRONT;
              default: begin
                // End of front porch: start the next frame without a gap
                // if still enabled, re-latching the pattern controls.
                if (gen_en) begin
                  state_d = ST_VSYNC;
                  pat_d   = pattern_sel;
                  solid_d = solid_color;
                end else begin
                  state_d = ST_IDLE;
                end
              end
            endcase
          end else begin
            line_cnt_d = line_cnt_q + 16'd1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 16'd1;
        end
      end
      default: begin
        // IDLE, and recovery from any unused encoding.
        h_cnt_d    = 16'd0;
        line_cnt_d = 16'd0;
        state_d    = ST_IDLE;
        if (gen_en) begin
          state_d = ST_VSYNC;
          pat_d   = pattern_sel;
          solid_d = solid_color;
        end
      end
    endcase
  end

  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      h_cnt_q    <= 16'd0;
      line_cnt_q <= 16'd0;
      pat_q      <= 2'd0;
      solid_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      h_cnt_q    <= h_cnt_d;
      line_cnt_q <= line_cnt_d;
      pat_q      <= pat_d;
      solid_q    <= solid_d;
    end
  end

  // Two bytes per pixel: h_cnt[0] selects the byte, the rest is the column.
  cmos_pattern_rom #(
    .H_PIXELS(H_PIXELS)
  ) u_rom (
    .pattern_sel_i(pat_q),
    .x_i          ({1'b0, h_cnt_q[15:1]}),
    .y_i          (line_cnt_q),
    .solid_color_i(solid_q),
    .pix_o        (pix)
  );

  // Outputs decode registered state only, so they move on cam_pclk edges.
  assign cam_vsync  = (state_q == ST_VSYNC);
  assign cam_href   = (state_q == ST_ACTIVE) && (h_cnt_q < ACT_CYC);
  assign frame_done = (state_q == ST_VFRONT) && line_end && seg_end;
  assign cam_data   = !cam_href  ? 8'h00 :
                      h_cnt_q[0] ? pix[7:0] : pix[15:8];

endmodule

// File: tb/tb_cmos_stream_gen.sv
`timescale 1ns/1ps
module tb_cmos_stream_gen;

  logic        cam_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gen_en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_done;

  cmos_stream_gen #(
    .H_PIXELS(10'd8),
    .V_LINES (10'd4),
    .H_BLANK (10'd4),
    .VS_LINES(10'd1),
    .V_BACK  (10'd1),
    .V_FRONT (10'd1)
  ) dut (
    .cam_pclk   (cam_pclk),
    .rst_n      (rst_n),
    .gen_en     (gen_en),
    .pattern_sel(pattern_sel),
    .solid_color(solid_color),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .frame_done (frame_done)
  );

  always #5 cam_pclk = ~cam_pclk;

  typedef struct {
    logic [7:0] b;
    int         fr;
    int         ln;
    int         px;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Hand-computed colour-bar line: 8 pixels, one per bar.
  logic [7:0] bars_line [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_frame(input int fr, input int pat, input logic [15:0] solid);
    logic [15:0] p;
    exp_t e;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        case (pat)
          0:       p = {bars_line[2*x], bars_line[2*x+1]};
          1:       p = 16'(x + y);
          2:       p = solid;
          default: p = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
        endcase
        e.fr = fr; e.ln = y; e.px = x;
        e.b = p[15:8];
        exp_q.push_back(e);
        e.b = p[7:0];
        exp_q.push_back(e);
      end
    end
  endtask

  // sel: 0 vsync, 1 href, 2 frame_done
  task automatic wait_high(input int sel, input int limit, input string name);
    int  n;
    logic v;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge cam_pclk);
      v = (sel == 0) ? cam_vsync : (sel == 1) ? cam_href : frame_done;
      if (v) begin
        done = 1'b1;
      end else begin
        n++;
        if (n >= limit) begin
          checks++;
          failures++;
          $display("FAIL wait_%s timed out after %0d cycles", name, n);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic quiet(input int n, input string name);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge cam_pclk);
      if (cam_vsync || cam_href || frame_done || (cam_data != 8'h00)) bad = 1'b1;
    end
    chk(name, {15'd0, bad}, 16'd0);
  endtask

  // Monitor: pops the scoreboard on every href byte and checks framing timing.
  int   cyc = 0;
  int   vs_rise = -1000;
  int   last_done = -1000;
  int   done_cnt = 0;
  int   b2b_cnt = 0;
  logic vs_prev = 1'b0;
  logic href_prev = 1'b0;
  logic done_prev = 1'b0;
  logic href_pend = 1'b0;

  always @(negedge cam_pclk) begin : monitor
    exp_t e;
    cyc++;
    if (cam_href === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_href_byte actual=%h required=no_byte", cam_data);
      end else begin
        e = exp_q.pop_front();
        if (cam_data !== e.b) begin
          failures++;
          $display("FAIL pix f%0d l%0d p%0d actual=%h required=%h", e.fr, e.ln, e.px, cam_data, e.b);
        end
      end
    end else if (cam_href === 1'b0) begin
      checks++;
      if (cam_data !== 8'h00) begin
        failures++;
        $display("FAIL data_when_href_low actual=%h required=00", cam_data);
      end
    end
    if (cam_vsync && !vs_prev) begin
      vs_rise = cyc;
      href_pend = 1'b1;
      if (cyc == last_done + 1) b2b_cnt++;
    end
    if (!cam_vsync && vs_prev) begin
      checks++;
      if (cyc - vs_rise != 20) begin
        failures++;
        $display("FAIL vsync_width actual=%0d required=20", cyc - vs_rise);
      end
    end
    if (cam_href && !href_prev && href_pend) begin
      href_pend = 1'b0;
      checks++;
      if (cyc - vs_rise != 40) begin
        failures++;
        $display("FAIL vsync_to_href actual=%0d required=40", cyc - vs_rise);
      end
    end
    if (frame_done) begin
      checks++;
      if ((cyc - vs_rise != 139) || done_prev) begin
        failures++;
        $display("FAIL frame_done_timing actual=%0d required=139 (repeat=%0b)", cyc - vs_rise, done_prev);
      end
      done_cnt++;
      last_done = cyc;
    end
    vs_prev   = cam_vsync;
    href_prev = cam_href;
    done_prev = frame_done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with gen_en low.
    repeat (4) @(negedge cam_pclk);
    chk("rst_vsync", {15'd0, cam_vsync}, 16'd0);
    chk("rst_href", {15'd0, cam_href}, 16'd0);
    chk("rst_data", {8'd0, cam_data}, 16'd0);
    chk("rst_done", {15'd0, frame_done}, 16'd0);

    // Frames 1 (bars) and 2 (ramp) back to back.
    push_frame(1, 0, 16'h0000);
    push_frame(2, 1, 16'h0000);
    rst_n  = 1'b1;
    gen_en = 1'b1;
    @(negedge cam_pclk);
    chk("vsync_after_release", {15'd0, cam_vsync}, 16'd1);
    wait_high(1, 100, "f1_href");
    pattern_sel = 2'd1;
    wait_high(2, 200, "f1_done");
    wait_high(0, 5, "f2_vsync");
    pattern_sel = 2'd2;
    solid_color = 16'hA5C3;
    push_frame(3, 2, 16'hA5C3);
    wait_high(2, 200, "f2_done");

    // Frame 3 (solid): drop gen_en during active line 1.
    wait_high(0, 5, "f3_vsync");
    repeat (65) @(negedge cam_pclk);
    gen_en = 1'b0;
    wait_high(2, 200, "f3_done");
    chk("f3_queue_empty", 16'(exp_q.size()), 16'd0);
    quiet(10, "idle_after_f3");
    chk("back_to_back_frames", 16'(b2b_cnt), 16'd2);

    // Frame 4 (checkerboard) aborted by a one-cycle reset mid-href.
    pattern_sel = 2'd3;
    gen_en = 1'b1;
    push_frame(4, 3, 16'h0000);
    wait_high(1, 100, "f4_href");
    repeat (3) @(negedge cam_pclk);
    rst_n  = 1'b0;
    gen_en = 1'b0;
    @(posedge cam_pclk);
    #1;
    chk("abort_href", {15'd0, cam_href}, 16'd0);
    chk("abort_data", {8'd0, cam_data}, 16'd0);
    exp_q.delete();
    @(negedge cam_pclk);
    rst_n = 1'b1;
    quiet(30, "idle_after_abort");

    // Frame 5: single checkerboard frame after restart.
    push_frame(5, 3, 16'h0000);
    gen_en = 1'b1;
    wait_high(0, 5, "f5_vsync");
    gen_en = 1'b0;
    wait_high(2, 200, "f5_done");
    chk("f5_queue_empty", 16'(exp_q.size()), 16'd0);
    quiet(5, "idle_after_f5");
    chk("frame_done_count", 16'(done_cnt), 16'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
